duck_line_scheduler: RTL and testbench



---
 rtl/duck_pkg.sv | 25 ++
 rtl/duck_slot_select.sv | 36 +++
 rtl/duck_line_scheduler.sv | 168 ++++++++++++++++
 tb/tb_duck_line_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck scanline scheduler.
// Slot records carry everything the active-video path needs to address the sprite ROM.
package duck_pkg;

  localparam int unsigned SPRITE_W  = 64;
  localparam int unsigned SPRITE_H  = 64;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned IDX_MAX_W = 6;

  typedef struct packed {
    logic                 valid;
    logic [9:0]           x;
    logic [5:0]           row;
    logic [IDX_MAX_W-1:0] idx;
  } slot_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StWait
  } state_e;

endpackage

// File: rtl/duck_slot_select.sv
// Combinational priority cover over the active slots; the lowest covering slot wins,
// which puts the lowest duck index on top because slots fill in index order.
module duck_slot_select
  import duck_pkg::*;
#(
  parameter int unsigned Slots   = 4,
  parameter int unsigned SpriteW = 64,
  localparam int unsigned ColW   = $clog2(SpriteW)
) (
  input  slot_t [Slots-1:0]     slots_i,
  input  logic  [9:0]           draw_x_i,
  output logic                  any_o,
  output logic  [IDX_MAX_W-1:0] win_idx_o,
  output logic  [5:0]           win_row_o,
  output logic  [ColW-1:0]      col_o
);

  always_comb begin
    any_o     = 1'b0;
    win_idx_o = '0;
    win_row_o = '0;
    col_o     = '0;
    // Walk from the highest slot down so the lowest covering slot is the final assignment.
    for (int s = Slots - 1; s >= 0; s--) begin
      if (slots_i[s].valid &&
          ({1'b0, draw_x_i} >= {1'b0, slots_i[s].x}) &&
          ({1'b0, draw_x_i} < ({1'b0, slots_i[s].x} + 11'(SpriteW)))) begin
        any_o     = 1'b1;
        win_idx_o = slots_i[s].idx;
        win_row_o = slots_i[s].row;
        col_o     = ColW'(draw_x_i - slots_i[s].x);
      end
    end
  end

endmodule

// File: rtl/duck_line_scheduler.sv
// Per-scanline duck sprite scheduler: scans the descriptor table during h-blank for the
// next line, commits at DrawX==0, then emits ROM address and coverage one cycle per pixel.
module duck_line_scheduler #(
  parameter int unsigned NUM_DUCKS = 8,
  parameter int unsigned SLOTS     = 4,
  parameter int unsigned SPRITE_W  = 64,
  parameter int unsigned SPRITE_H  = 64,
  parameter int unsigned SCAN_X    = 640,
  parameter int unsigned V_TOTAL   = 525,
  localparam int unsigned IdxW     = (NUM_DUCKS > 1) ? $clog2(NUM_DUCKS) : 1
) (
  input  logic            vga_clk,
  input  logic            reset,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            blank,
  output logic [IdxW-1:0] desc_idx,
  input  logic            desc_valid,
  input  logic [9:0]      desc_x,
  input  logic [9:0]      desc_y,
  output logic [11:0]     rom_address,
  output logic            pix_valid,
  output logic [IdxW-1:0] pix_duck,
  output logic            line_overflow
);

  import duck_pkg::slot_t;
  import duck_pkg::state_e;
  import duck_pkg::StIdle;
  import duck_pkg::StScan;
  import duck_pkg::StWait;
  import duck_pkg::IDX_MAX_W;

  localparam int unsigned CntW = 8;
  localparam int unsigned PendW = $clog2(SLOTS + 1);
  localparam int unsigned ColW = $clog2(SPRITE_W);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [9:0]             y_next_q, y_next_d;
  slot_t [SLOTS-1:0]      pend_q, pend_d, act_q, act_d;
  logic [PendW-1:0]       pend_cnt_q, pend_cnt_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic                   line_ovf_q, line_ovf_d;
  logic                   pix_valid_q, pix_valid_d;
  logic [11:0]            rom_q, rom_d;
  logic [IdxW-1:0]        pix_duck_q, pix_duck_d;

  logic                   hit;
  logic                   any_cover;
  logic [IDX_MAX_W-1:0]   win_idx;
  logic [5:0]             win_row;
  logic [ColW-1:0]        win_col;

  // 11-bit compare so a duck near the bottom never wraps into low rows.
  assign hit = desc_valid &&
               ({1'b0, y_next_q} >= {1'b0, desc_y}) &&
               ({1'b0, y_next_q} < ({1'b0, desc_y} + 11'(SPRITE_H)));

  assign desc_idx = (state_q == StScan && cnt_q < CntW'(NUM_DUCKS)) ? IdxW'(cnt_q) : '0;

  duck_slot_select #(
    .Slots   (SLOTS),
    .SpriteW (SPRITE_W)
  ) u_slot_select (
    .slots_i   (act_q),
    .draw_x_i  (DrawX),
    .any_o     (any_cover),
    .win_idx_o (win_idx),
    .win_row_o (win_row),
    .col_o     (win_col)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    y_next_d   = y_next_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    pend_ovf_d = pend_ovf_q;
    act_d      = act_q;
    line_ovf_d = line_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (DrawX == 10'(SCAN_X)) begin
          state_d    = StScan;
          cnt_d      = '0;
          y_next_d   = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
          pend_d     = '0;
          pend_cnt_d = '0;
          pend_ovf_d = 1'b0;
        end
      end
      StScan: begin
        cnt_d = cnt_q + 8'd1;
        // Data on the descriptor bus belongs to the index driven one cycle earlier.
        if (cnt_q != '0 && hit) begin
          if (pend_cnt_q < PendW'(SLOTS)) begin
            for (int s = 0; s < SLOTS; s++) begin
              if (pend_cnt_q == PendW'(s)) begin
                pend_d[s].valid = 1'b1;
                pend_d[s].x     = desc_x;
                pend_d[s].row   = 6'(y_next_q - desc_y);
                pend_d[s].idx   = IDX_MAX_W'(cnt_q - 8'd1);
              end
            end
            pend_cnt_d = pend_cnt_q + PendW'(1);
          end else begin
            pend_ovf_d = 1'b1;
          end
        end
        if (cnt_q == CntW'(NUM_DUCKS)) state_d = StWait;
      end
      StWait: begin
        if (DrawX == 10'd0) begin
          state_d    = StIdle;
          act_d      = pend_q;
          line_ovf_d = pend_ovf_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_valid_d = blank && any_cover;
    rom_d       = '0;
    pix_duck_d  = '0;
    if (pix_valid_d) begin
      rom_d      = 12'({win_row, win_col});
      pix_duck_d = IdxW'(win_idx);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      y_next_q    <= '0;
      pend_q      <= '0;
      pend_cnt_q  <= '0;
      pend_ovf_q  <= 1'b0;
      act_q       <= '0;
      line_ovf_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      rom_q       <= '0;
      pix_duck_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_next_q    <= y_next_d;
      pend_q      <= pend_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_ovf_q  <= pend_ovf_d;
      act_q       <= act_d;
      line_ovf_q  <= line_ovf_d;
      pix_valid_q <= pix_valid_d;
      rom_q       <= rom_d;
      pix_duck_q  <= pix_duck_d;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign rom_address   = rom_q;
  assign pix_duck      = pix_duck_q;
  assign line_overflow = line_ovf_q;

endmodule

// File: tb/tb_duck_line_scheduler.sv
// Self-checking bench for duck_line_scheduler: directed scenarios plus randomized lines,
// compared against a table-level model of which ducks land on each scanline.
module tb_duck_line_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [2:0]  desc_idx;
  logic        desc_valid;
  logic [9:0]  desc_x, desc_y;
  logic [11:0] rom_address;
  logic        pix_valid;
  logic [2:0]  pix_duck;
  logic        line_overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Descriptor table seen by the DUT, and the snapshot the model believes is on screen.
  bit dv[8];
  int dx[8], dy[8];
  bit a_dv[8];
  int a_dx[8], a_dy[8];
  int act_line;
  bit act_valid;

  duck_line_scheduler u_dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .desc_idx      (desc_idx),
    .desc_valid    (desc_valid),
    .desc_x        (desc_x),
    .desc_y        (desc_y),
    .rom_address   (rom_address),
    .pix_valid     (pix_valid),
    .pix_duck      (pix_duck),
    .line_overflow (line_overflow)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the descriptor table answers like a synchronous ROM.
  task automatic tick();
    int i;
    i = int'(desc_idx);
    @(posedge vga_clk);
    #1;
    desc_valid = dv[i];
    desc_x     = 10'(dx[i]);
    desc_y     = 10'(dy[i]);
  endtask

  function automatic bit on_line(input int k, input int ln);
    return a_dv[k] && ln >= a_dy[k] && ln < a_dy[k] + 64;
  endfunction

  function automatic bit exp_ovf();
    int n;
    n = 0;
    if (!act_valid) return 1'b0;
    for (int k = 0; k < 8; k++) if (on_line(k, act_line)) n++;
    return n > 4;
  endfunction

  // First four ducks on the line (in index order) are drawn; the lowest covering index wins.
  task automatic exp_pix(input int x, input bit bl, output bit v, output int d, output int a);
    int rank;
    v = 1'b0; d = 0; a = 0; rank = 0;
    if (act_valid && bl) begin
      for (int k = 0; k < 8; k++) begin
        if (on_line(k, act_line)) begin
          rank++;
          if (!v && rank <= 4 && x >= a_dx[k] && x < a_dx[k] + 64) begin
            v = 1'b1;
            d = k;
            a = (act_line - a_dy[k]) * 64 + (x - a_dx[k]);
          end
        end
      end
    end
  endtask

  task automatic clear_table();
    for (int k = 0; k < 8; k++) begin
      dv[k] = 1'b0; dx[k] = 0; dy[k] = 0;
    end
  endtask

  // Run the h-blank scan on the line before ln, then commit at DrawX==0 of line ln.
  task automatic scan_and_commit(input int ln, input bit chk_idx);
    DrawY = 10'((ln == 0) ? 524 : ln - 1);
    blank = 1'b0;
    for (int x = 636; x < 652; x++) begin
      DrawX = 10'(x);
      if (chk_idx && x >= 641 && x <= 650)
        check_eq("desc_idx_seq", desc_idx, (x - 641 < 8) ? 32'(x - 641) : 32'd0);
      tick();
    end
    DrawX = 10'd0;
    DrawY = 10'(ln);
    blank = (ln < 480);
    tick();
    for (int k = 0; k < 8; k++) begin
      a_dv[k] = dv[k]; a_dx[k] = dx[k]; a_dy[k] = dy[k];
    end
    act_line  = ln;
    act_valid = 1'b1;
    check_eq("line_overflow", line_overflow, exp_ovf());
  endtask

  task automatic pixel(input int x, input bit bl);
    bit v;
    int d, a;
    DrawX = 10'(x);
    blank = bl;
    tick();
    exp_pix(x, bl, v, d, a);
    check_eq("pix_valid", pix_valid, v);
    check_eq("pix_duck", pix_duck, d);
    check_eq("rom_address", rom_address, a);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pix_valid"}, pix_valid, 0);
    check_eq({tag, "_rom_address"}, rom_address, 0);
    check_eq({tag, "_pix_duck"}, pix_duck, 0);
    check_eq({tag, "_line_overflow"}, line_overflow, 0);
    check_eq({tag, "_desc_idx"}, desc_idx, 0);
  endtask

  initial begin
    int ln, x, k;
    bit bl;
    reset = 1'b1;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    desc_valid = 1'b0; desc_x = '0; desc_y = '0;
    act_valid = 1'b0; act_line = 0;
    clear_table();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;

    // Single duck.
    dv[0] = 1'b1; dx[0] = 100; dy[0] = 50;
    scan_and_commit(60, 1'b1);
    pixel(130, 1'b1);
    check_eq("single_rom_670", rom_address, 670);
    pixel(164, 1'b1);
    check_eq("single_edge_off", pix_valid, 0);

    // Overlap priority.
    clear_table();
    dv[1] = 1'b1; dx[1] = 100; dy[1] = 50;
    dv[3] = 1'b1; dx[3] = 120; dy[3] = 50;
    scan_and_commit(55, 1'b1);
    pixel(130, 1'b1);
    check_eq("overlap_duck", pix_duck, 1);
    check_eq("overlap_rom_350", rom_address, 350);

    // Overflow: five ducks on one line.
    clear_table();
    for (int i = 0; i < 5; i++) begin
      dv[i] = 1'b1; dx[i] = 70 * i; dy[i] = 200;
    end
    scan_and_commit(210, 1'b0);
    check_eq("ovf_set", line_overflow, 1);
    for (int i = 0; i < 5; i++) pixel(70 * i + 10, 1'b1);
    check_eq("ovf_duck4_dropped", pix_valid, 0);
    scan_and_commit(270, 1'b0);
    check_eq("ovf_clear", line_overflow, 0);

    // Vertical wrap and bottom edge.
    clear_table();
    dv[0] = 1'b1; dx[0] = 300; dy[0] = 0;
    dv[2] = 1'b1; dx[2] = 400; dy[2] = 50;
    scan_and_commit(0, 1'b0);
    pixel(310, 1'b1);
    check_eq("wrap_row0_rom", rom_address, 10);
    scan_and_commit(113, 1'b0);
    pixel(410, 1'b1);
    check_eq("bottom_row_valid", pix_valid, 1);
    scan_and_commit(114, 1'b0);
    pixel(410, 1'b1);
    check_eq("below_duck_valid", pix_valid, 0);

    // Blank gating past the visible edge.
    clear_table();
    dv[5] = 1'b1; dx[5] = 620; dy[5] = 0;
    scan_and_commit(10, 1'b1);
    pixel(630, 1'b1);
    pixel(650, 1'b0);
    check_eq("blank_gate", pix_valid, 0);

    // Reset in the middle of a scan.
    clear_table();
    dv[0] = 1'b1; dx[0] = 100; dy[0] = 50;
    scan_and_commit(60, 1'b0);
    pixel(130, 1'b1);
    DrawY = 10'd60;
    blank = 1'b0;
    for (int xi = 636; xi <= 643; xi++) begin
      DrawX = 10'(xi);
      tick();
    end
    reset = 1'b1;
    act_valid = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    #1;
    reset = 1'b0;
    for (int xi = 644; xi < 652; xi++) begin
      DrawX = 10'(xi);
      tick();
    end
    DrawX = 10'd0; DrawY = 10'd61; blank = 1'b1;
    tick();
    pixel(130, 1'b1);
    check_eq("after_reset_blank_line", pix_valid, 0);
    scan_and_commit(62, 1'b1);
    pixel(130, 1'b1);
    check_eq("after_reset_redraw", pix_valid, 1);

    // Randomized tables and lines.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 8; i++) begin
        dv[i] = ($urandom_range(3, 0) != 0);
        dx[i] = $urandom_range(760, 0);
        dy[i] = $urandom_range(524, 0);
      end
      ln = $urandom_range(524, 0);
      if (t % 4 == 0) begin
        // Crowd a line so overflow and priority are exercised often.
        for (int i = 0; i < 8; i++) dy[i] = (ln >= 30) ? ln - $urandom_range(30, 0) : ln;
      end
      scan_and_commit(ln, t < 4);
      for (int p = 0; p < 30; p++) begin
        k = $urandom_range(7, 0);
        x = (p % 2 == 0) ? dx[k] + $urandom_range(70, 0) - 3 : $urandom_range(799, 0);
        if (x < 0) x = 0;
        if (x > 799) x = 799;
        if (x == 640) x = 639;
        bl = (x < 640) && (ln < 480) && ($urandom_range(15, 0) != 0);
        pixel(x, bl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
